// File: rtl/microseq_pkg.sv
// Shared encodings for the microsequencer: branch modes, LC-3 condition
// select codes, and the mapping from a condition code to the j-field bit it
// modifies.
package microseq_pkg;

  typedef enum logic [1:0] {
    MODE_BRANCH = 2'b00,
    MODE_CALL   = 2'b01,
    MODE_RET    = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_e;

  localparam int COND_NONE  = 0;
  localparam int COND_R     = 1;
  localparam int COND_BEN   = 2;
  localparam int COND_IR11  = 3;
  localparam int COND_PSR15 = 4;
  localparam int COND_INT   = 5;
  localparam int COND_ACV   = 6;

  // Returned for codes that add no OR term.
  localparam int POS_NONE = -1;

  // j-field bit position that a condition code ORs its flag into.
  function automatic int cond_bit_pos(input int code);
    case (code)
      COND_R:     return 1;
      COND_BEN:   return 2;
      COND_IR11:  return 0;
      COND_PSR15: return 3;
      COND_INT:   return 4;
      COND_ACV:   return 5;
      default:    return POS_NONE;
    endcase
  endfunction

endpackage

// File: rtl/micro_stack.sv
// Micro-return LIFO: register array plus depth counter. At most one push or
// pop per cycle; pushes when full and pops when empty are ignored here (the
// caller raises the sticky error flags). Hold freezes contents and depth.
module micro_stack #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       hold,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           push_data,
  output logic [WIDTH-1:0]           top,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] depth
);

  localparam int DW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DW-1:0]    depth_q;
  logic [DW-1:0]    top_pos;
  logic             do_push;
  logic             do_pop;

  assign full    = (depth_q == DW'(DEPTH));
  assign empty   = (depth_q == '0);
  assign depth   = depth_q;
  assign do_push = push && !full && !hold;
  assign do_pop  = pop && !empty && !hold;
  assign top_pos = depth_q - DW'(1);

  // Top-of-stack read; the value is meaningless when empty, so drive zero.
  always_comb begin
    top = '0;
    if (!empty) top = mem[top_pos[IW-1:0]];
  end

  // Depth counter; reset empties the stack.
  always_ff @(posedge clk) begin
    if (rst) begin
      depth_q <= '0;
    end else if (do_push) begin
      depth_q <= depth_q + DW'(1);
    end else if (do_pop) begin
      depth_q <= depth_q - DW'(1);
    end
  end

  // Entry storage; contents are don't-care after reset so no reset term.
  always_ff @(posedge clk) begin
    if (do_push) mem[depth_q[IW-1:0]] <= push_data;
  end

endmodule

// File: rtl/microsequencer_seq.sv
// Clocked LC-3 style next-address logic with a micro-subroutine stack,
// stall, and sticky stack error flags. The next address is combinational
// from the current control-store fields; the uPC register, stack and flags
// commit on each unstalled clock edge.
module microsequencer_seq #(
  parameter int ADDR_W      = 6,
  parameter int COND_W      = 3,
  parameter int STACK_DEPTH = 4,
  parameter int RESET_ADDR  = 18
) (
  input  logic                             i_Clk,
  input  logic                             i_Reset,
  input  logic [ADDR_W-1:0]                i_j_field,
  input  logic [COND_W-1:0]                i_COND_bits,
  input  logic                             i_IRD,
  input  logic [1:0]                       i_Mode,
  input  logic [(2**COND_W)-1:0]           i_CondVec,
  input  logic [3:0]                       i_Opcode,
  input  logic                             i_Stall,
  output logic [ADDR_W-1:0]                o_uPC,
  output logic [ADDR_W-1:0]                o_AddressNextState,
  output logic [$clog2(STACK_DEPTH+1)-1:0] o_StackDepth,
  output logic                             o_StackOverflow,
  output logic                             o_StackUnderflow
);

  import microseq_pkg::*;

  logic [ADDR_W-1:0] upc_q;
  logic [ADDR_W-1:0] next_addr;
  logic [ADDR_W-1:0] cond_term;
  logic [ADDR_W-1:0] stack_top;
  logic [ADDR_W-1:0] ret_addr;
  logic              push;
  logic              pop;
  logic              set_ovf;
  logic              set_unf;
  logic              stk_full;
  logic              stk_empty;
  logic              ovf_q;
  logic              unf_q;
  int                pos;
  mode_e             mode;

  assign mode     = mode_e'(i_Mode);
  assign ret_addr = upc_q + ADDR_W'(1);

  // Condition OR term: selected flag shifted to its mapped j-field bit.
  // Code 0, unmapped codes and positions beyond the address add nothing.
  always_comb begin
    cond_term = '0;
    pos       = cond_bit_pos(int'(i_COND_bits));
    for (int k = 0; k < ADDR_W; k++) begin
      if (i_COND_bits != '0 && pos == k) cond_term[k] = i_CondVec[i_COND_bits];
    end
  end

  // Next-address priority mux and stack/flag requests.
  always_comb begin
    next_addr = '0;
    push      = 1'b0;
    pop       = 1'b0;
    set_ovf   = 1'b0;
    set_unf   = 1'b0;
    if (i_IRD) begin
      next_addr[3:0] = i_Opcode;
    end else if (mode == MODE_RET) begin
      if (!stk_empty) begin
        next_addr = stack_top;
        pop       = 1'b1;
      end else begin
        next_addr = ADDR_W'(RESET_ADDR);
        set_unf   = 1'b1;
      end
    end else begin
      next_addr = i_j_field | cond_term;
      if (mode == MODE_CALL) begin
        if (!stk_full) push = 1'b1;
        else           set_ovf = 1'b1;
      end
    end
  end

  micro_stack #(
    .DEPTH (STACK_DEPTH),
    .WIDTH (ADDR_W)
  ) u_stack (
    .clk       (i_Clk),
    .rst       (i_Reset),
    .hold      (i_Stall),
    .push      (push),
    .pop       (pop),
    .push_data (ret_addr),
    .top       (stack_top),
    .full      (stk_full),
    .empty     (stk_empty),
    .depth     (o_StackDepth)
  );

  // uPC register and sticky flags; reset beats stall, stall holds all.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      upc_q <= ADDR_W'(RESET_ADDR);
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (!i_Stall) begin
      upc_q <= next_addr;
      if (set_ovf) ovf_q <= 1'b1;
      if (set_unf) unf_q <= 1'b1;
    end
  end

  assign o_uPC              = upc_q;
  assign o_AddressNextState = next_addr;
  assign o_StackOverflow    = ovf_q;
  assign o_StackUnderflow   = unf_q;

endmodule

// File: tb/tb_microsequencer_seq.sv
// Bench for microsequencer_seq: a table of single-cycle vectors followed by
// hand-built call/return, overflow/underflow, stall and reset sequences.
// Next address is checked mid-cycle; post-edge state comes off a queue.
module tb_microsequencer_seq;

  logic       i_Clk = 1'b0;
  logic       i_Reset;
  logic [5:0] i_j_field;
  logic [2:0] i_COND_bits;
  logic       i_IRD;
  logic [1:0] i_Mode;
  logic [7:0] i_CondVec;
  logic [3:0] i_Opcode;
  logic       i_Stall;
  logic [5:0] o_uPC;
  logic [5:0] o_AddressNextState;
  logic [2:0] o_StackDepth;
  logic       o_StackOverflow;
  logic       o_StackUnderflow;

  int checks = 0;
  int errors = 0;

  microsequencer_seq #(
    .ADDR_W      (6),
    .COND_W      (3),
    .STACK_DEPTH (4),
    .RESET_ADDR  (18)
  ) dut (
    .i_Clk              (i_Clk),
    .i_Reset            (i_Reset),
    .i_j_field          (i_j_field),
    .i_COND_bits        (i_COND_bits),
    .i_IRD              (i_IRD),
    .i_Mode             (i_Mode),
    .i_CondVec          (i_CondVec),
    .i_Opcode           (i_Opcode),
    .i_Stall            (i_Stall),
    .o_uPC              (o_uPC),
    .o_AddressNextState (o_AddressNextState),
    .o_StackDepth       (o_StackDepth),
    .o_StackOverflow    (o_StackOverflow),
    .o_StackUnderflow   (o_StackUnderflow)
  );

  always #5 i_Clk = ~i_Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  typedef struct {
    logic [5:0] j;
    logic [2:0] c;
    logic       ird;
    logic [1:0] mode;
    logic [7:0] cv;
    logic [3:0] op;
    logic       stall;
    logic [5:0] exp_next;
    logic [5:0] exp_upc;
    logic [2:0] exp_depth;
    logic       exp_ovf;
    logic       exp_unf;
  } vec_t;

  typedef struct {
    logic [5:0] upc;
    logic [2:0] depth;
    logic       ovf;
    logic       unf;
  } exp_t;

  exp_t sb_q[$];

  // Reference model state for the hand-written sequences.
  int   m_upc;
  int   m_stk[$];
  logic m_ovf;
  logic m_unf;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [5:0] j, input logic [2:0] c, input logic ird,
                              input logic [1:0] mode, input logic [7:0] cv, input logic [3:0] op,
                              input logic [5:0] nxt, input logic [2:0] d);
    vec_t v;
    v.j = j; v.c = c; v.ird = ird; v.mode = mode; v.cv = cv; v.op = op;
    v.stall = 1'b0; v.exp_next = nxt; v.exp_upc = nxt; v.exp_depth = d;
    v.exp_ovf = 1'b0; v.exp_unf = 1'b0;
    return v;
  endfunction

  // Called just after a rising edge: drive, check next mid-cycle, then
  // compare the committed state after the following edge.
  task automatic drive(input vec_t v, input string tag);
    exp_t e;
    exp_t got;
    i_j_field   = v.j;
    i_COND_bits = v.c;
    i_IRD       = v.ird;
    i_Mode      = v.mode;
    i_CondVec   = v.cv;
    i_Opcode    = v.op;
    i_Stall     = v.stall;
    @(negedge i_Clk);
    chk({tag, " next"}, int'(o_AddressNextState), int'(v.exp_next));
    e.upc = v.exp_upc; e.depth = v.exp_depth; e.ovf = v.exp_ovf; e.unf = v.exp_unf;
    sb_q.push_back(e);
    @(posedge i_Clk);
    #1;
    got = sb_q.pop_front();
    chk({tag, " uPC"},   int'(o_uPC),            int'(got.upc));
    chk({tag, " depth"}, int'(o_StackDepth),     int'(got.depth));
    chk({tag, " ovf"},   int'(o_StackOverflow),  int'(got.ovf));
    chk({tag, " unf"},   int'(o_StackUnderflow), int'(got.unf));
  endtask

  task automatic step_call(input int j, input string tag);
    vec_t v;
    v = mk(6'(j), 3'd0, 1'b0, 2'b01, 8'h00, 4'h0, 6'(j), 3'd0);
    if (m_stk.size() < 4) m_stk.push_back((m_upc + 1) % 64);
    else                  m_ovf = 1'b1;
    m_upc = j;
    v.exp_depth = 3'(m_stk.size());
    v.exp_ovf = m_ovf; v.exp_unf = m_unf;
    drive(v, tag);
  endtask

  task automatic step_ret(input string tag);
    vec_t v;
    int   nxt;
    if (m_stk.size() > 0) nxt = m_stk.pop_back();
    else begin
      nxt   = 18;
      m_unf = 1'b1;
    end
    m_upc = nxt;
    v = mk(6'd0, 3'd0, 1'b0, 2'b10, 8'h00, 4'h0, 6'(nxt), 3'(m_stk.size()));
    v.exp_ovf = m_ovf; v.exp_unf = m_unf;
    drive(v, tag);
  endtask

  vec_t tbl[20];

  initial begin
    vec_t v;

    tbl[0]  = mk(6'd33, 3'd0, 1'b0, 2'b00, 8'h00, 4'h0, 6'd33, 3'd0);
    tbl[1]  = mk(6'd0,  3'd2, 1'b0, 2'b00, 8'h04, 4'h0, 6'd4,  3'd0);
    tbl[2]  = mk(6'd0,  3'd2, 1'b0, 2'b00, 8'h00, 4'h0, 6'd0,  3'd0);
    tbl[3]  = mk(6'd16, 3'd6, 1'b0, 2'b00, 8'h40, 4'h0, 6'd48, 3'd0);
    tbl[4]  = mk(6'd8,  3'd3, 1'b0, 2'b00, 8'h08, 4'h0, 6'd9,  3'd0);
    tbl[5]  = mk(6'd5,  3'd7, 1'b0, 2'b00, 8'hFF, 4'h0, 6'd5,  3'd0);
    tbl[6]  = mk(6'd5,  3'd1, 1'b0, 2'b00, 8'h02, 4'h0, 6'd7,  3'd0);
    tbl[7]  = mk(6'd0,  3'd4, 1'b0, 2'b00, 8'h10, 4'h0, 6'd8,  3'd0);
    tbl[8]  = mk(6'd1,  3'd5, 1'b0, 2'b00, 8'h20, 4'h0, 6'd17, 3'd0);
    tbl[9]  = mk(6'd0,  3'd0, 1'b1, 2'b10, 8'h00, 4'hC, 6'd12, 3'd0);
    tbl[10] = mk(6'd10, 3'd0, 1'b0, 2'b00, 8'h00, 4'h0, 6'd10, 3'd0);
    tbl[11] = mk(6'd40, 3'd0, 1'b0, 2'b01, 8'h00, 4'h0, 6'd40, 3'd1);
    tbl[12] = mk(6'd0,  3'd0, 1'b0, 2'b10, 8'h00, 4'h0, 6'd11, 3'd0);
    tbl[13] = mk(6'd32, 3'd2, 1'b0, 2'b01, 8'h04, 4'h0, 6'd36, 3'd1);
    tbl[14] = mk(6'd0,  3'd0, 1'b1, 2'b01, 8'h00, 4'h3, 6'd3,  3'd1);
    tbl[15] = mk(6'd0,  3'd0, 1'b0, 2'b10, 8'h00, 4'h0, 6'd12, 3'd0);
    tbl[16] = mk(6'd63, 3'd0, 1'b0, 2'b00, 8'h00, 4'h0, 6'd63, 3'd0);
    tbl[17] = mk(6'd20, 3'd0, 1'b0, 2'b01, 8'h00, 4'h0, 6'd20, 3'd1);
    tbl[18] = mk(6'd0,  3'd0, 1'b0, 2'b10, 8'h00, 4'h0, 6'd0,  3'd0);
    tbl[19] = mk(6'd7,  3'd0, 1'b0, 2'b11, 8'h00, 4'h0, 6'd7,  3'd0);

    i_Reset = 1'b1; i_Stall = 1'b0; i_j_field = 6'd33; i_COND_bits = 3'd0;
    i_IRD = 1'b0; i_Mode = 2'b00; i_CondVec = 8'h00; i_Opcode = 4'h0;
    repeat (2) @(posedge i_Clk);
    #1;
    chk("reset uPC",   int'(o_uPC), 18);
    chk("reset depth", int'(o_StackDepth), 0);
    chk("reset ovf",   int'(o_StackOverflow), 0);
    chk("reset unf",   int'(o_StackUnderflow), 0);
    i_Reset = 1'b0;

    for (int i = 0; i < 20; i++) drive(tbl[i], $sformatf("vec%0d", i));

    // Fill past capacity, then drain past empty.
    m_upc = 7; m_ovf = 1'b0; m_unf = 1'b0;
    for (int i = 0; i < 5; i++) step_call(40 + i, $sformatf("call%0d", i));
    for (int i = 0; i < 5; i++) step_ret($sformatf("ret%0d", i));

    // Two nested calls, then stalled call/return attempts change nothing.
    step_call(30, "nest0");
    step_call(31, "nest1");
    for (int i = 0; i < 3; i++) begin
      v = mk(6'(60 + i), 3'd0, 1'b0, 2'b01, 8'h00, 4'h0, 6'(60 + i), 3'd2);
      v.stall = 1'b1; v.exp_upc = 6'd31; v.exp_ovf = 1'b1; v.exp_unf = 1'b1;
      drive(v, $sformatf("stallcall%0d", i));
    end
    v = mk(6'd0, 3'd0, 1'b0, 2'b10, 8'h00, 4'h0, 6'd31, 3'd2);
    v.stall = 1'b1; v.exp_upc = 6'd31; v.exp_ovf = 1'b1; v.exp_unf = 1'b1;
    drive(v, "stallret");

    // Reset mid-subroutine, with stall and a call pending.
    i_Reset = 1'b1; i_Stall = 1'b1; i_Mode = 2'b01; i_j_field = 6'd50;
    @(posedge i_Clk);
    #1;
    chk("midreset uPC",   int'(o_uPC), 18);
    chk("midreset depth", int'(o_StackDepth), 0);
    chk("midreset ovf",   int'(o_StackOverflow), 0);
    chk("midreset unf",   int'(o_StackUnderflow), 0);
    i_Reset = 1'b0; i_Stall = 1'b0;

    m_upc = 18; m_stk.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    step_ret("postreset ret");
    step_call(5, "postreset call");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/microsequencer_seq.md
# microsequencer_seq

Clocked, parametrised successor of the LC-3 next-address logic. Holds the current micro-address (uPC) in a register, computes the next address from control-store fields, and adds a micro-subroutine call/return stack, a stall input and sticky stack-error flags. Sits between the control store, which is indexed by `o_uPC`, and the datapath and memory condition sources.

## Interface

Parameters:
- `ADDR_W`, default 6: micro-address width (≥ 5; at least the 4-bit opcode plus a nonzero prefix).
- `COND_W`, default 3: width of the condition-select field.
- `STACK_DEPTH`, default 4: number of micro-return stack entries (≥ 1).
- `RESET_ADDR`, default 18: uPC value after reset and after an underflow (LC-3 fetch state).

Ports (clock and reset first):
- `i_Clk` in 1: the block's only clock.
- `i_Reset` in 1: synchronous, active-high reset.
- `i_j_field` in ADDR_W: base next address from the control store.
- `i_COND_bits` in COND_W: condition select; 0 means unconditional.
- `i_IRD` in 1: opcode dispatch.
- `i_Mode` in 2: 00 branch, 01 call, 10 return, 11 reserved (treated as branch).
- `i_CondVec` in 2^COND_W: condition flags; bit k is the flag tested when `i_COND_bits` = k. Bit 0 is ignored.
- `i_Opcode` in 4: IR[15:12].
- `i_Stall` in 1: hold all state.
- `o_uPC` out ADDR_W: registered current micro-address.
- `o_AddressNextState` out ADDR_W: combinational next address.
- `o_StackDepth` out clog2(STACK_DEPTH+1): number of valid stack entries.
- `o_StackOverflow` out 1: sticky overflow flag.
- `o_StackUnderflow` out 1: sticky underflow flag.

## Operation

Next-address selection, highest priority first:
- **IRD = 1:** next = {zeros, `i_Opcode`}. `i_Mode` is ignored and there is no stack operation.
- **Return (`i_Mode` = 10), stack not empty:** next = top of stack; pop.
- **Return, stack empty:** next = RESET_ADDR; set `o_StackUnderflow`.
- **Otherwise:** next = `i_j_field` OR (`i_CondVec[c]` << POS(c)), where c = `i_COND_bits`. No OR term when c = 0.
  - POS is the package function `cond_bit_pos`. LC-3 default mapping: 1 (R) → 1, 2 (BEN) → 2, 3 (IR11) → 0, 4 (PSR15) → 3, 5 (INT) → 4, 6 (ACV) → 5.
  - Codes above 6, or positions ≥ ADDR_W, add no OR term.
- **Call (`i_Mode` = 01) on this branch path:** target computed as above.
  - Stack not full: push (`o_uPC` + 1) mod 2^ADDR_W.
  - Stack full: no push, set `o_StackOverflow`, still jump to the target.

Stack:
- LIFO built from a register array and a depth counter.
- At most one push or pop per cycle. Call and return are mutually exclusive by encoding.
- Flags are sticky until reset.

Stall (`i_Stall` = 1):
- `o_uPC`, stack contents, depth and flags all hold.
- `o_AddressNextState` is still computed and driven.

## Timing

- `o_AddressNextState` is purely combinational from the current inputs and the stack top; zero latency.
- On each rising `i_Clk` edge with `i_Reset` = 0 and `i_Stall` = 0: `o_uPC` ← `o_AddressNextState`, and the stack operation and flag updates commit.
- Control-store fields are expected to be valid in the same cycle as the `o_uPC` that addressed them (asynchronous ROM); one micro-instruction per cycle.
- Reset values: `o_uPC` = RESET_ADDR, `o_StackDepth` = 0, both flags = 0, stack entries don't-care.
- Reset wins over stall and over any pending call or return, including mid-subroutine: the stack is emptied with no flag set.
- Wrap-around: return address RESET at max address+1 wraps to 0.
- A call in the same cycle as a stall performs no push.

## Structure

- Package `microseq_pkg`: mode encodings (MODE_BRANCH, MODE_CALL, MODE_RET), LC-3 condition codes (COND_R, COND_BEN, COND_IR11, COND_PSR15, COND_INT, COND_ACV), and the function `cond_bit_pos`.
- One sub-module, `micro_stack`: a parametrised LIFO with push/pop/full/empty/depth and hold.
- The top level contains the next-address mux and the uPC register.

## Test plan

1. Reset, then idle with branch mode, c = 0, j = 33 → `o_uPC` = 18 in the reset cycle, 33 one cycle later, both flags 0.
2. c = 2 (BEN), j = 0, `i_CondVec[2]` = 1 → next = 4; with the flag at 0 → next = 0. c = 6 (ACV), j = 16, flag 1 → next = 48.
3. IRD = 1, opcode 4'b1100, `i_Mode` = 10 → next = 12; depth unchanged.
4. With uPC = 10, call j = 40 → uPC = 40, depth 1. Then return → uPC = 11, depth 0.
5. Five calls with STACK_DEPTH = 4 → overflow set on the 5th, depth stays 4. Then five returns → the 5th goes to 18 and sets underflow.
6. Stall held for 3 cycles during a call → no uPC, depth or flag change. Reset asserted with depth 2 → depth 0, uPC = 18, flags 0.
